rv32_exec_datapath: RTL and testbench
=====================================

Name: rv32_exec_datapath

Overview:
- Execute datapath slice for the team's RV32I cores: 32x32 register file, combinational ALU and a 32-bit enabled result register.
- Two asynchronous read ports, one synchronous write port.
- ALU operands are muxed between register-file read data and external operands; flags are reported alongside the result.
- The sequencer/FSM drives all control inputs each cycle.

Parameters:
- RES_RESET, 32'h0000_0000: value loaded into the result register on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_ena  in  1  register-file write enable.
- wr_addr  in  5  write address.
- wr_data  in  32  write data.
- rd_addr0  in  5  read port 0 address.
- rd_addr1  in  5  read port 1 address.
- rd_data0  out  32  read port 0 data.
- rd_data1  out  32  read port 1 data.
- a_sel  in  1  0: ALU a = rd_data0; 1: ALU a = ext_a.
- b_sel  in  1  0: ALU b = rd_data1; 1: ALU b = ext_b.
- ext_a  in  32  external operand a.
- ext_b  in  32  external operand b.
- alu_control  in  4  alu_control_t operation.
- alu_result  out  32  combinational ALU result.
- overflow  out  1  signed overflow (ADD/SUB only).
- zero  out  1  alu_result == 0.
- equal  out  1  a == b.
- res_ena  in  1  result register enable.
- res_q  out  32  registered ALU result.

Behaviour:
- Reset: on posedge clk with rst=1, registers x1..x31 clear to 0 and res_q loads RES_RESET. rst has priority over wr_ena and res_ena.
- x0: always reads 0; writes to address 0 are ignored.
- Write: on posedge clk with wr_ena=1 and rst=0, regs[wr_addr] <= wr_data.
- Read: asynchronous. rd_dataN = regs[rd_addrN], with 0 for address 0.
- Same-cycle read/write to the same address: read returns the old value until the edge, then the new value (no bypass, unless the optional feature is enabled).
- Both read ports may address the same register.
- Result register: on posedge with res_ena=1, res_q <= alu_result. Otherwise res_q holds. One-cycle latency from the operands.
- ALU operations, all 32-bit with wrap-around:
  - ADD: a+b. SUB: a-b.
  - AND, OR, XOR: bitwise.
  - SLL, SRL, SRA: shift by b[4:0] only; SRA sign-extends.
  - SLT: signed compare, result 1 or 0.
  - SLTU: unsigned compare, result 1 or 0.
  - INVALID and any unlisted code: result 0.
- overflow:
  - ADD: 1 when a[31]==b[31] and result[31]!=a[31].
  - SUB: 1 when a[31]!=b[31] and result[31]!=a[31].
  - All other operations: 0.
- zero = (alu_result == 0).
- equal = (a == b) on the muxed operands, independent of alu_control.
- Outputs are pure combinational functions of current inputs and state; no X propagates when inputs are known.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wr_ena=1, wr_addr!=0 and rd_addrN==wr_addr, rd_dataN = wr_data combinationally (write-to-read forwarding in the same cycle).
- Undefined: no forwarding; a read returns the stored value as specified above.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_control_t: ALU_INVALID=4'b0000, ALU_AND=4'b0001, ALU_OR=4'b0010, ALU_XOR=4'b0011, ALU_SLL=4'b0101, ALU_SRL=4'b0110, ALU_SRA=4'b0111, ALU_ADD=4'b1000, ALU_SUB=4'b1100, ALU_SLT=4'b1101, ALU_SLTU=4'b1111.
  - Function alu_control_name() returning a string, for debug display.
- One sub-module, dp_register (params N, RESET; ports clk, rst, ena, d, q): synchronous reset, enabled load.
- dp_register is instantiated for the result register and for each of x1..x31.

Test Plan:
- Reset then read: rst for 1 cycle; read all 32 addresses -> every read 0; res_q = RES_RESET.
- Write/readback: write x5=32'hDEAD_BEEF; write x0=32'h1234; read ports 0/1 at 5/0 -> 32'hDEAD_BEEF / 0. A same-cycle read of x5 before the edge returns the old value, or the new value under REGFILE_BYPASS_EN.
- ADD overflow: a=32'h7FFF_FFFF, b=1, ADD -> result 32'h8000_0000, overflow=1, zero=0. SUB with a=b=32'h5 -> result 0, zero=1, equal=1, overflow=0.
- Shifts/compares on a=32'h8000_0000:
  - b=32'h21, SRA -> 32'hC000_0000 (shift by 1); SRL -> 32'h4000_0000.
  - b=1: SLT -> 1; SLTU -> 0.
- Operand mux and result register: x3=10, ext_b=32'hFFFF_FFFF, a_sel=0, b_sel=1, ADD, res_ena=1 -> after one edge res_q=9. With res_ena=0 and new operands, res_q stays 9.
- Reset mid-operation: wr_ena=1 and res_ena=1 asserted together with rst -> after the edge the target register reads 0 and res_q = RES_RESET.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : ALU operation encoding and a debug name helper for the RV32I
//            execute datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_INVALID = 4'b0000,
        ALU_AND     = 4'b0001,
        ALU_OR      = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SLL     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_ADD     = 4'b1000,
        ALU_SUB     = 4'b1100,
        ALU_SLT     = 4'b1101,
        ALU_SLTU    = 4'b1111
    } alu_control_t;

    function automatic string alu_control_name(input logic [3:0] op);
        case (op)
            ALU_INVALID: return "INVALID";
            ALU_AND:     return "AND";
            ALU_OR:      return "OR";
            ALU_XOR:     return "XOR";
            ALU_SLL:     return "SLL";
            ALU_SRL:     return "SRL";
            ALU_SRA:     return "SRA";
            ALU_ADD:     return "ADD";
            ALU_SUB:     return "SUB";
            ALU_SLT:     return "SLT";
            ALU_SLTU:    return "SLTU";
            default:     return "UNKNOWN";
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dp_register.sv
// ============================================================================
// Module   : dp_register
// Brief    : N-bit register with synchronous active-high reset and load enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_register #(
    parameter int         N     = 32,
    parameter logic [N-1:0] RESET = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32_exec_datapath.sv
// ============================================================================
// Module   : rv32_exec_datapath
// Brief    : RV32I execute slice: 32x32 register file, combinational ALU and
//            enabled result register. Optional macro REGFILE_BYPASS_EN enables
//            same-cycle write-to-read forwarding on both read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_exec_datapath
    import alu_pkg::*;
#(
    parameter logic [31:0] RES_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ena,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    input  logic        a_sel,
    input  logic        b_sel,
    input  logic [31:0] ext_a,
    input  logic [31:0] ext_b,
    input  logic [3:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        overflow,
    output logic        zero,
    output logic        equal,
    input  logic        res_ena,
    output logic [31:0] res_q
);

    logic [31:0][31:0] regs;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       add_res;
    logic [31:0]       sub_res;
    logic [4:0]        shamt;

    // x0 is hardwired; only x1..x31 hold state
    assign regs[0] = '0;

    for (genvar i = 1; i < 32; i++) begin : g_regs
        logic we;
        assign we = wr_ena && (wr_addr == 5'(i));

        dp_register #(
            .N     (32),
            .RESET (32'h0000_0000)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .ena (we),
            .d   (wr_data),
            .q   (regs[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_data0 = (wr_ena && (wr_addr != 5'd0) && (rd_addr0 == wr_addr)) ? wr_data : regs[rd_addr0];
    assign rd_data1 = (wr_ena && (wr_addr != 5'd0) && (rd_addr1 == wr_addr)) ? wr_data : regs[rd_addr1];
`else
    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];
`endif

    assign a       = a_sel ? ext_a : rd_data0;
    assign b       = b_sel ? ext_b : rd_data1;
    assign add_res = a + b;
    assign sub_res = a - b;
    assign shamt   = b[4:0];

    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        case (alu_control)
            ALU_AND:  alu_result = a & b;
            ALU_OR:   alu_result = a | b;
            ALU_XOR:  alu_result = a ^ b;
            ALU_SLL:  alu_result = a << shamt;
            ALU_SRL:  alu_result = a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(a) >>> shamt);
            ALU_ADD: begin
                alu_result = add_res;
                overflow   = (a[31] == b[31]) && (add_res[31] != a[31]);
            end
            ALU_SUB: begin
                alu_result = sub_res;
                overflow   = (a[31] != b[31]) && (sub_res[31] != a[31]);
            end
            ALU_SLT:  alu_result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_result = {31'b0, (a < b)};
            default:  alu_result = '0;
        endcase
    end

    assign zero  = (alu_result == 32'd0);
    assign equal = (a == b);

    dp_register #(
        .N     (32),
        .RESET (RES_RESET)
    ) u_res (
        .clk (clk),
        .rst (rst),
        .ena (res_ena),
        .d   (alu_result),
        .q   (res_q)
    );

endmodule

`default_nettype wire

// File: tb/tb_rv32_exec_datapath.sv
// ============================================================================
// Module   : tb_rv32_exec_datapath
// Brief    : Directed self-checking bench for rv32_exec_datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_exec_datapath;
    import alu_pkg::*;

    localparam logic [31:0] RES_INIT = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;
    logic        a_sel;
    logic        b_sel;
    logic [31:0] ext_a;
    logic [31:0] ext_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        overflow;
    logic        zero;
    logic        equal;
    logic        res_ena;
    logic [31:0] res_q;

    int tests  = 0;
    int failed = 0;

    rv32_exec_datapath #(
        .RES_RESET (RES_INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ena      (wr_ena),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr0    (rd_addr0),
        .rd_addr1    (rd_addr1),
        .rd_data0    (rd_data0),
        .rd_data1    (rd_data1),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .ext_a       (ext_a),
        .ext_b       (ext_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .overflow    (overflow),
        .zero        (zero),
        .equal       (equal),
        .res_ena     (res_ena),
        .res_q       (res_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_ext(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        a_sel       = 1'b1;
        b_sel       = 1'b1;
        ext_a       = av;
        ext_b       = bv;
        alu_control = op;
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0; a_sel = 1'b0; b_sel = 1'b0;
        ext_a = '0; ext_b = '0; alu_control = ALU_INVALID; res_ena = 1'b0;

        // Reset and read back every address on both ports
        tick();
        rst = 1'b0;
        #1;
        check("reset_res_q", res_q, RES_INIT);
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd0_x%0d", i), rd_data0, 32'h0);
            check($sformatf("reset_rd1_x%0d", 31 - i), rd_data1, 32'h0);
        end

        // Write x5, observe old/forwarded value before the edge
        wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        rd_addr0 = 5'd5; rd_addr1 = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x5_before_edge", rd_data0, 32'hDEAD_BEEF);
`else
        check("x5_before_edge", rd_data0, 32'h0);
`endif
        tick();
        check("x5_after_edge", rd_data0, 32'hDEAD_BEEF);
        check("x5_both_ports", rd_data1, 32'hDEAD_BEEF);

        // Write to x0 is dropped
        wr_addr = 5'd0; wr_data = 32'h0000_1234; rd_addr1 = 5'd0;
        #1;
        check("x0_before_edge", rd_data1, 32'h0);
        tick();
        wr_ena = 1'b0;
        #1;
        check("x0_after_write", rd_data1, 32'h0);
        check("x5_port0_kept", rd_data0, 32'hDEAD_BEEF);

        // ALU on external operands
        alu_ext(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        check("add_ovf_result", alu_result, 32'h8000_0000);
        check("add_ovf_flag", 32'(overflow), 32'h1);
        check("add_ovf_zero", 32'(zero), 32'h0);
        check("add_ovf_equal", 32'(equal), 32'h0);

        alu_ext(ALU_SUB, 32'h5, 32'h5);
        check("sub_eq_result", alu_result, 32'h0);
        check("sub_eq_zero", 32'(zero), 32'h1);
        check("sub_eq_equal", 32'(equal), 32'h1);
        check("sub_eq_ovf", 32'(overflow), 32'h0);

        alu_ext(ALU_SUB, 32'h8000_0000, 32'h1);
        check("sub_ovf_result", alu_result, 32'h7FFF_FFFF);
        check("sub_ovf_flag", 32'(overflow), 32'h1);

        alu_ext(ALU_AND, 32'h7FFF_FFFF, 32'h1);
        check("and_no_ovf", 32'(overflow), 32'h0);

        alu_ext(ALU_SRA, 32'h8000_0000, 32'h21);
        check("sra", alu_result, 32'hC000_0000);
        alu_ext(ALU_SRL, 32'h8000_0000, 32'h21);
        check("srl", alu_result, 32'h4000_0000);
        alu_ext(ALU_SLL, 32'h8000_0000, 32'h21);
        check("sll_out", alu_result, 32'h0);
        check("sll_zero", 32'(zero), 32'h1);
        alu_ext(ALU_SLL, 32'h0000_0003, 32'h4);
        check("sll_4", alu_result, 32'h0000_0030);
        alu_ext(ALU_SLT, 32'h8000_0000, 32'h1);
        check("slt", alu_result, 32'h1);
        alu_ext(ALU_SLTU, 32'h8000_0000, 32'h1);
        check("sltu", alu_result, 32'h0);

        alu_ext(ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        check("and", alu_result, 32'h00F0_000F);
        alu_ext(ALU_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        check("or", alu_result, 32'hFFF0_0FFF);
        alu_ext(ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        check("xor", alu_result, 32'hFF00_0FF0);
        alu_ext(ALU_INVALID, 32'h1234_5678, 32'h1);
        check("invalid", alu_result, 32'h0);
        alu_ext(4'b1001, 32'h1234_5678, 32'h1);
        check("unlisted", alu_result, 32'h0);

        // Register operand on b via port 1
        rd_addr1 = 5'd5; b_sel = 1'b0; ext_a = 32'hDEAD_BEF0; alu_control = ALU_SUB;
        #1;
        check("sub_ext_a_reg_b", alu_result, 32'h1);

        // Operand mux and result register
        wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'd10;
        tick();
        wr_ena = 1'b0;
        rd_addr0 = 5'd3; a_sel = 1'b0; b_sel = 1'b1; ext_b = 32'hFFFF_FFFF;
        alu_control = ALU_ADD; res_ena = 1'b1;
        #1;
        check("mux_alu_result", alu_result, 32'd9);
        tick();
        check("res_q_load", res_q, 32'd9);
        res_ena = 1'b0; ext_b = 32'd5;
        #1;
        check("mux_alu_new", alu_result, 32'd15);
        tick();
        check("res_q_hold", res_q, 32'd9);

        // Reset wins over simultaneous write and result load
        rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'd77; res_ena = 1'b1;
        tick();
        rst = 1'b0; wr_ena = 1'b0; res_ena = 1'b0;
        rd_addr0 = 5'd3; rd_addr1 = 5'd5;
        #1;
        check("rst_mid_x3", rd_data0, 32'h0);
        check("rst_mid_x5", rd_data1, 32'h0);
        check("rst_mid_res_q", res_q, RES_INIT);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
